// File: rtl/decomp_pkg.sv
// Shared types and constants for the word decompressor.
package decomp_pkg;

   localparam int DEF_WORD_W     = 32;
   localparam int DEF_DICT_DEPTH = 16;

   localparam logic [1:0] CODE_ZZZZ = 2'b00;
   localparam logic [1:0] CODE_XXXX = 2'b01;
   localparam logic [1:0] CODE_MMMM = 2'b10;
   localparam logic [1:0] CODE_EXT  = 2'b11;

   typedef logic [DEF_WORD_W-1:0] dict_word_t;

endpackage

// File: rtl/decomp_dict_ptr.sv
// FIFO-replacement write pointer and saturating valid-entry count for the
// decompressor dictionary; also provides the two write target indices.
module decomp_dict_ptr
   import decomp_pkg::*;
#(
   parameter int DICT_DEPTH = DEF_DICT_DEPTH,
   parameter int IDX_W      = $clog2(DICT_DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_flush,
   input  logic             i_valid,
   input  logic [1:0]       i_wr_ctrl,
   output logic [IDX_W-1:0] o_wr_idx0,
   output logic [IDX_W-1:0] o_wr_idx1,
   output logic [IDX_W-1:0] o_wr_ptr,
   output logic [IDX_W:0]   o_count,
   output logic             o_full
);

   localparam logic [IDX_W+1:0] DEPTH_EXT = (IDX_W+2)'(DICT_DEPTH);

   logic [IDX_W-1:0] wr_ptr_q;
   logic [IDX_W:0]   count_q;
   logic             full_q;
   logic [1:0]       n_wr;
   logic [IDX_W+1:0] count_sum;
   logic [IDX_W:0]   count_nxt;

   always_comb begin
      n_wr = 2'd0;
      if (i_valid) n_wr = {1'b0, i_wr_ctrl[0]} + {1'b0, i_wr_ctrl[1]};
      count_sum = {1'b0, count_q} + {{IDX_W{1'b0}}, n_wr};
      count_nxt = (count_sum > DEPTH_EXT) ? DEPTH_EXT[IDX_W:0] : count_sum[IDX_W:0];
   end

   // Flush behaves exactly like reset for the bookkeeping state.
   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         wr_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_q + {{(IDX_W-2){1'b0}}, n_wr};
         count_q  <= count_nxt;
         full_q   <= ({1'b0, count_nxt} == DEPTH_EXT);
      end
   end

   assign o_wr_idx0 = wr_ptr_q;
   assign o_wr_idx1 = wr_ptr_q + 1'b1;
   assign o_wr_ptr  = wr_ptr_q;
   assign o_count   = count_q;
   assign o_full    = full_q;

endmodule

// File: rtl/decomp_dict_update.sv
// Dictionary storage/update stage: writes up to two words per cycle and serves
// two combinational read ports. DICT_WR_BYPASS_EN forwards same-cycle writes.
module decomp_dict_update
   import decomp_pkg::*;
#(
   parameter int WORD_W     = DEF_WORD_W,
   parameter int DICT_DEPTH = DEF_DICT_DEPTH,
   parameter int IDX_W      = $clog2(DICT_DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_valid,
   input  logic [1:0]        i_wr_ctrl,
   input  logic [WORD_W-1:0] i_word0,
   input  logic [WORD_W-1:0] i_word1,
   input  logic              i_flush,
   input  logic [IDX_W-1:0]  i_rd_idx0,
   input  logic [IDX_W-1:0]  i_rd_idx1,
   output logic [WORD_W-1:0] o_rd_word0,
   output logic [WORD_W-1:0] o_rd_word1,
   output logic [IDX_W-1:0]  o_wr_ptr,
   output logic [IDX_W:0]    o_count,
   output logic              o_full
);

   logic [WORD_W-1:0]     mem [DICT_DEPTH];
   logic [DICT_DEPTH-1:0] valid_q;
   logic [IDX_W-1:0]      wr_idx0;
   logic [IDX_W-1:0]      wr_idx1;
   logic                  wr_go;
   logic                  we0;
   logic                  we1;
   logic [WORD_W-1:0]     wd0;

   decomp_dict_ptr #(.DICT_DEPTH(DICT_DEPTH), .IDX_W(IDX_W)) u_ptr (
      .clk       (clk),
      .reset     (reset),
      .i_flush   (i_flush),
      .i_valid   (i_valid),
      .i_wr_ctrl (i_wr_ctrl),
      .o_wr_idx0 (wr_idx0),
      .o_wr_idx1 (wr_idx1),
      .o_wr_ptr  (o_wr_ptr),
      .o_count   (o_count),
      .o_full    (o_full)
   );

   // A lone word1 still lands at the pointer slot, so slot 0 takes word1 for ctrl=10.
   assign wr_go = i_valid && !i_flush && !reset;
   assign we0   = wr_go && (i_wr_ctrl != 2'b00);
   assign we1   = wr_go && (i_wr_ctrl == 2'b11);
   assign wd0   = (i_wr_ctrl == 2'b10) ? i_word1 : i_word0;

   always_ff @(posedge clk) begin
      if (we0) mem[wr_idx0] <= wd0;
      if (we1) mem[wr_idx1] <= i_word1;
   end

   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         valid_q <= '0;
      end else begin
         if (we0) valid_q[wr_idx0] <= 1'b1;
         if (we1) valid_q[wr_idx1] <= 1'b1;
      end
   end

   always_comb begin
      o_rd_word0 = valid_q[i_rd_idx0] ? mem[i_rd_idx0] : '0;
      o_rd_word1 = valid_q[i_rd_idx1] ? mem[i_rd_idx1] : '0;
`ifdef DICT_WR_BYPASS_EN
      // Second target checked last so word1 wins on a double hit.
      if (i_valid && !i_flush) begin
         if (i_wr_ctrl != 2'b00 && i_rd_idx0 == wr_idx0) o_rd_word0 = wd0;
         if (i_wr_ctrl == 2'b11 && i_rd_idx0 == wr_idx1) o_rd_word0 = i_word1;
         if (i_wr_ctrl != 2'b00 && i_rd_idx1 == wr_idx0) o_rd_word1 = wd0;
         if (i_wr_ctrl == 2'b11 && i_rd_idx1 == wr_idx1) o_rd_word1 = i_word1;
      end
`endif
   end

   a_wr_ctrl_known : assert property (@(posedge clk) disable iff (reset)
      i_valid |-> !$isunknown(i_wr_ctrl));

endmodule

// File: tb/tb_decomp_dict_update.sv
// Self-checking bench for decomp_dict_update against an array/pointer model.
module tb_decomp_dict_update;

   localparam int D = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_valid;
   logic [1:0]  i_wr_ctrl;
   logic [31:0] i_word0;
   logic [31:0] i_word1;
   logic        i_flush;
   logic [3:0]  i_rd_idx0;
   logic [3:0]  i_rd_idx1;
   logic [31:0] o_rd_word0;
   logic [31:0] o_rd_word1;
   logic [3:0]  o_wr_ptr;
   logic [4:0]  o_count;
   logic        o_full;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_mem [D];
   bit          m_vld [D];
   int          m_ptr;
   int          m_cnt;

   always #5 clk = ~clk;

   decomp_dict_update dut (
      .clk        (clk),
      .reset      (reset),
      .i_valid    (i_valid),
      .i_wr_ctrl  (i_wr_ctrl),
      .i_word0    (i_word0),
      .i_word1    (i_word1),
      .i_flush    (i_flush),
      .i_rd_idx0  (i_rd_idx0),
      .i_rd_idx1  (i_rd_idx1),
      .o_rd_word0 (o_rd_word0),
      .o_rd_word1 (o_rd_word1),
      .o_wr_ptr   (o_wr_ptr),
      .o_count    (o_count),
      .o_full     (o_full)
   );

   function automatic logic [31:0] exp_rd(int idx);
      return m_vld[idx] ? m_mem[idx] : 32'h0;
   endfunction

   task automatic model_step(bit rst, bit fl, bit v, logic [1:0] c, logic [31:0] w0, logic [31:0] w1);
      logic [31:0] q[$];
      if (rst || fl) begin
         foreach (m_vld[i]) m_vld[i] = 0;
         m_ptr = 0;
         m_cnt = 0;
         return;
      end
      if (!v) return;
      if (c[0]) q.push_back(w0);
      if (c[1]) q.push_back(w1);
      foreach (q[k]) begin
         m_mem[m_ptr] = q[k];
         m_vld[m_ptr] = 1;
         m_ptr = (m_ptr + 1) % D;
         if (m_cnt < D) m_cnt++;
      end
   endtask

   task automatic drive(bit rst, bit fl, bit v, logic [1:0] c, logic [31:0] w0, logic [31:0] w1);
      reset = rst; i_flush = fl; i_valid = v; i_wr_ctrl = c; i_word0 = w0; i_word1 = w1;
      @(posedge clk);
      #1;
      model_step(rst, fl, v, c, w0, w1);
      reset = 0; i_flush = 0; i_valid = 0; i_wr_ctrl = 2'b00;
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 2'b00, 0, 0);
      drive(1, 0, 1, 2'b11, 32'h1111_1111, 32'h2222_2222);
      n_checks++;
      if (o_wr_ptr !== 4'd0 || o_count !== 5'd0 || o_full !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: ptr=%0d count=%0d full=%0b, required 0/0/0", o_wr_ptr, o_count, o_full);
      end
      for (int i = 0; i < D; i++) begin
         i_rd_idx0 = 4'(i); i_rd_idx1 = 4'(D-1-i); #1;
         n_checks++;
         if (o_rd_word0 !== 32'h0 || o_rd_word1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_read idx=%0d: got %h/%h, required 0/0", i, o_rd_word0, o_rd_word1);
         end
      end
   endtask

   task automatic test_pair_write();
      drive(1, 0, 0, 2'b00, 0, 0);
      drive(0, 0, 1, 2'b11, 32'hAAAA_0001, 32'hAAAA_0002);
      i_rd_idx0 = 4'd0; i_rd_idx1 = 4'd1; #1;
      n_checks++;
      if (o_rd_word0 !== 32'hAAAA_0001 || o_rd_word1 !== 32'hAAAA_0002) begin
         n_fail++;
         $display("FAIL pair_entries: got %h/%h, required aaaa0001/aaaa0002", o_rd_word0, o_rd_word1);
      end
      n_checks++;
      if (o_wr_ptr !== 4'd2 || o_count !== 5'd2 || o_full !== 1'b0) begin
         n_fail++;
         $display("FAIL pair_state: ptr=%0d count=%0d full=%0b, required 2/2/0", o_wr_ptr, o_count, o_full);
      end
      i_rd_idx0 = 4'd2; #1;
      n_checks++;
      if (o_rd_word0 !== 32'h0) begin
         n_fail++;
         $display("FAIL pair_unwritten: got %h, required 0", o_rd_word0);
      end
   endtask

   task automatic test_wrap();
      drive(1, 0, 0, 2'b00, 0, 0);
      for (int i = 0; i < 15; i++) drive(0, 0, 1, 2'b01, 32'h100 + i, $urandom);
      drive(0, 0, 1, 2'b11, 32'hF, 32'h10);
      i_rd_idx0 = 4'd15; i_rd_idx1 = 4'd0; #1;
      n_checks++;
      if (o_rd_word0 !== 32'hF || o_rd_word1 !== 32'h10) begin
         n_fail++;
         $display("FAIL wrap_entries: got %h/%h, required f/10", o_rd_word0, o_rd_word1);
      end
      n_checks++;
      if (o_wr_ptr !== 4'd1 || o_count !== 5'd16 || o_full !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_state: ptr=%0d count=%0d full=%0b, required 1/16/1", o_wr_ptr, o_count, o_full);
      end
   endtask

   task automatic test_overwrite();
      drive(0, 0, 1, 2'b10, 32'hDEAD_0000, 32'h1234);
      i_rd_idx0 = 4'd1; i_rd_idx1 = 4'd2; #1;
      n_checks++;
      if (o_rd_word0 !== 32'h1234 || o_rd_word1 !== exp_rd(2)) begin
         n_fail++;
         $display("FAIL overwrite_entries: got %h/%h, required 1234/%h", o_rd_word0, o_rd_word1, exp_rd(2));
      end
      n_checks++;
      if (o_wr_ptr !== 4'd2 || o_count !== 5'd16 || o_full !== 1'b1) begin
         n_fail++;
         $display("FAIL overwrite_state: ptr=%0d count=%0d full=%0b, required 2/16/1", o_wr_ptr, o_count, o_full);
      end
   endtask

   task automatic test_idle();
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 2'b11, $urandom, $urandom);
      n_checks++;
      if (o_wr_ptr !== 4'(m_ptr) || o_count !== 5'(m_cnt) || o_full !== (m_cnt == D)) begin
         n_fail++;
         $display("FAIL idle_state: ptr=%0d count=%0d, required %0d/%0d", o_wr_ptr, o_count, m_ptr, m_cnt);
      end
      for (int i = 0; i < D; i++) begin
         i_rd_idx0 = 4'(i); i_rd_idx1 = 4'(D-1-i); #1;
         n_checks++;
         if (o_rd_word0 !== exp_rd(i) || o_rd_word1 !== exp_rd(D-1-i)) begin
            n_fail++;
            $display("FAIL idle_read idx=%0d: got %h/%h, required %h/%h", i, o_rd_word0, o_rd_word1, exp_rd(i), exp_rd(D-1-i));
         end
      end
   endtask

   task automatic test_clear(bit use_reset);
      for (int i = 0; i < 5; i++) drive(0, 0, 1, 2'($urandom_range(1, 3)), $urandom, $urandom);
      drive(use_reset, !use_reset, 1, 2'b11, 32'h5555_AAAA, 32'h6666_BBBB);
      n_checks++;
      if (o_wr_ptr !== 4'd0 || o_count !== 5'd0 || o_full !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_state rst=%0b: ptr=%0d count=%0d full=%0b, required 0/0/0", use_reset, o_wr_ptr, o_count, o_full);
      end
      for (int i = 0; i < D; i++) begin
         i_rd_idx0 = 4'(i); i_rd_idx1 = 4'(i); #1;
         n_checks++;
         if (o_rd_word0 !== 32'h0 || o_rd_word1 !== 32'h0) begin
            n_fail++;
            $display("FAIL clear_read rst=%0b idx=%0d: got %h/%h, required 0/0", use_reset, i, o_rd_word0, o_rd_word1);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         drive(0, ($urandom_range(0, 39) == 0), $urandom_range(0, 1), 2'($urandom),
               $urandom, $urandom);
         i_rd_idx0 = 4'($urandom); i_rd_idx1 = 4'($urandom); #1;
         n_checks++;
         if (o_wr_ptr !== 4'(m_ptr) || o_count !== 5'(m_cnt) || o_full !== (m_cnt == D)) begin
            n_fail++;
            $display("FAIL random_state n=%0d: ptr=%0d count=%0d full=%0b, required %0d/%0d/%0b",
                     n, o_wr_ptr, o_count, o_full, m_ptr, m_cnt, (m_cnt == D));
         end
         n_checks++;
         if (o_rd_word0 !== exp_rd(i_rd_idx0) || o_rd_word1 !== exp_rd(i_rd_idx1)) begin
            n_fail++;
            $display("FAIL random_read n=%0d idx=%0d/%0d: got %h/%h, required %h/%h", n, i_rd_idx0, i_rd_idx1,
                     o_rd_word0, o_rd_word1, exp_rd(i_rd_idx0), exp_rd(i_rd_idx1));
         end
      end
   endtask

   task automatic test_bypass();
      logic [31:0] exp0;
      logic [31:0] old4;
      drive(1, 0, 0, 2'b00, 0, 0);
      for (int i = 0; i < 19; i++) drive(0, 0, 1, 2'b01, 32'h7700 + i, 0);
      old4 = exp_rd(4);
`ifdef DICT_WR_BYPASS_EN
      exp0 = 32'hBEEF;
`else
      exp0 = exp_rd(3);
`endif
      i_valid = 1; i_wr_ctrl = 2'b01; i_word0 = 32'hBEEF; i_word1 = 32'h0;
      i_rd_idx0 = 4'd3; i_rd_idx1 = 4'd4; #1;
      n_checks++;
      if (o_rd_word0 !== exp0 || o_rd_word1 !== old4) begin
         n_fail++;
         $display("FAIL bypass_same_cycle: got %h/%h, required %h/%h", o_rd_word0, o_rd_word1, exp0, old4);
      end
      @(posedge clk);
      #1;
      model_step(0, 0, 1, 2'b01, 32'hBEEF, 32'h0);
      i_valid = 0; i_wr_ctrl = 2'b00; #1;
      n_checks++;
      if (o_rd_word0 !== 32'hBEEF || o_wr_ptr !== 4'd4) begin
         n_fail++;
         $display("FAIL bypass_after_edge: got %h ptr=%0d, required beef ptr=4", o_rd_word0, o_wr_ptr);
      end
   endtask

   initial begin
      reset = 1; i_valid = 0; i_wr_ctrl = 0; i_word0 = 0; i_word1 = 0;
      i_flush = 0; i_rd_idx0 = 0; i_rd_idx1 = 0;
      m_ptr = 0; m_cnt = 0;
      foreach (m_vld[i]) m_vld[i] = 0;
      test_reset();
      test_pair_write();
      test_wrap();
      test_overwrite();
      test_idle();
      test_clear(0);
      test_clear(1);
      test_random();
      test_bypass();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decomp_dict_update.md
Name: decomp_dict_update

Overview:
- Dictionary storage and update stage of the word decompressor.
- Sits directly downstream of the write-control generator in the two-words-per-cycle decompress path.
- Consumes the 2-bit per-word write-enable vector plus the two reconstructed words and writes enabled words into a FIFO-replacement dictionary.
- Serves two combinational read ports to the word reconstruction logic for match/partial-match lookups.

Parameters:
- WORD_W, 32, width of one dictionary word.
- DICT_DEPTH, 16, number of entries; power of two, at least 4.
- IDX_W, $clog2(DICT_DEPTH), index and pointer width.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- i_valid  input  1  word pair and i_wr_ctrl are valid this cycle.
- i_wr_ctrl  input  2  bit0 writes i_word0; bit1 writes i_word1 (the ctrl_signal produced upstream).
- i_word0  input  WORD_W  first reconstructed word.
- i_word1  input  WORD_W  second reconstructed word.
- i_flush  input  1  block boundary; invalidate the whole dictionary.
- i_rd_idx0  input  IDX_W  lookup index, port 0.
- i_rd_idx1  input  IDX_W  lookup index, port 1.
- o_rd_word0  output  WORD_W  entry at i_rd_idx0; 0 if the entry is invalid.
- o_rd_word1  output  WORD_W  entry at i_rd_idx1; 0 if the entry is invalid.
- o_wr_ptr  output  IDX_W  next entry to be written.
- o_count  output  IDX_W+1  number of valid entries, saturating at DICT_DEPTH.
- o_full  output  1  o_count == DICT_DEPTH.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high: on a clk edge with reset=1, wr_ptr=0, count=0, all valid bits=0, o_full=0. Entry data need not be reset.
- Reset or flush mid-stream: reset and i_flush take priority over a same-cycle i_valid write. The write is dropped and the state goes to its reset values.
- Write gating: a write happens only when i_valid=1.
  - i_wr_ctrl=00: no state change.
  - 01: entry[wr_ptr]<=i_word0; wr_ptr+=1.
  - 10: entry[wr_ptr]<=i_word1; wr_ptr+=1.
  - 11: entry[wr_ptr]<=i_word0, entry[wr_ptr+1]<=i_word1; wr_ptr+=2.
- Word order: word0 is always older than word1.
- Wrap-around: all pointer arithmetic is modulo DICT_DEPTH. Pointer DEPTH-1 with two writes puts word0 at DEPTH-1, word1 at 0, and the new wr_ptr is 1.
- Replacement: the oldest entry is overwritten once full. The valid bit of each written entry is set.
- count: increments by the number of writes and saturates at DICT_DEPTH. With count = DEPTH-1 and two writes, count = DEPTH.
- Latency: a write is visible to the read ports in the cycle after the write edge.
- Reads: purely combinational from the registered array (read-old-data by default). Both ports may address the same index.
- Outputs: o_wr_ptr, o_count and o_full are registered state, updated on the same edge as the write.
- i_valid=0 with a nonzero i_wr_ctrl: the control bits are ignored.
- Assertion: flag any X on i_wr_ctrl while i_valid=1.

Optional Feature:
- Macro: DICT_WR_BYPASS_EN.
- Defined: a read whose index equals a same-cycle write target returns the incoming word combinationally (word1 wins if both targets match, which cannot occur for DEPTH >= 2). Bypass applies only when i_valid=1 and i_flush=0.
- Not defined: reads always return array contents as of the last edge. The upstream scheduler guarantees no same-cycle reference to a word being written.

Decomposition:
- Package decomp_pkg holds:
  - WORD_W and DICT_DEPTH defaults;
  - code localparams CODE_ZZZZ=2'b00, CODE_XXXX=2'b01, CODE_MMMM=2'b10, CODE_EXT=2'b11;
  - typedef dict_word_t.
- One sub-module: decomp_dict_ptr, which owns wr_ptr, count, and the computation of the two write target indices (ptr, ptr+1 mod DEPTH). The storage array and the read muxes stay in the top module.

Test Plan:
- Reset then i_valid=1, ctrl=11, word0=0xAAAA0001, word1=0xAAAA0002 -> next cycle: entry0 = 0xAAAA0001, entry1 = 0xAAAA0002, o_wr_ptr=2, o_count=2; reading idx 2 returns 0.
- 15 single writes (ctrl=01), then ctrl=11 with word0=0xF, word1=0x10 -> entry15 = 0xF, entry0 = 0x10, o_wr_ptr=1, o_count=16, o_full=1.
- Full dictionary, ctrl=10 with word1=0x1234 -> overwrites the oldest entry at wr_ptr; count stays 16.
- i_valid=0 with ctrl=11 for 5 cycles -> pointer, count and contents unchanged.
- i_flush=1 together with i_valid=1, ctrl=11 -> next cycle: o_count=0, o_wr_ptr=0, all reads return 0. Repeat the same check with reset=1 asserted mid-stream.
- DICT_WR_BYPASS_EN defined: write ctrl=01 word0=0xBEEF at ptr 3 while i_rd_idx0=3 -> o_rd_word0=0xBEEF in the same cycle. Without the macro, o_rd_word0 returns the previous contents.
